// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch path: fetch FSM states, instruction
// size and the branch word-offset scaling.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned WORD_SHIFT       = 2;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential PC+4 or taken conditional branch.
// Kept separate so a later jump extension can reuse the same adder path.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] instr_pc_i,
    input  logic              branch_i,
    input  logic              alu_zero_i,
    input  logic [31:0]       branch_offset_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] offset_bytes;
    logic [ADDR_W-1:0] target;
    logic              taken;

    // Offset is a signed word count; sign-extend before scaling to bytes.
    assign offset_bytes = ADDR_W'($signed(branch_offset_i)) << WORD_SHIFT;
    assign pc_plus4_o   = instr_pc_i + ADDR_W'(INSTR_BYTES);
    assign target       = pc_plus4_o + offset_bytes;
    assign taken        = branch_i & alu_zero_i;
    assign next_pc_o    = taken ? target : pc_plus4_o;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: fetches from instruction memory and hands each word to
// decode over a valid/ready handshake, advancing the PC on acceptance.
//
// state | meaning
// BOOT  | one idle cycle after reset, no memory request
// FETCH | request at pc until imem_ack_i, capture word
// HOLD  | word presented to decode, wait for instr_ready_i
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    input  logic              branch_i,
    input  logic              alu_zero_i,
    input  logic [31:0]       branch_offset_i,
    output logic [31:0]       instr_count_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
        .instr_pc_i      (instr_pc_q),
        .branch_i        (branch_i),
        .alu_zero_i      (alu_zero_i),
        .branch_offset_i (branch_offset_i),
        .pc_plus4_o      (pc_plus4_o),
        .next_pc_o       (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ack_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && instr_ready_i) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Acks outside FETCH never reach the capture path because req is low there.
    assign imem_req_o    = (state_q == FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_count_o = count_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and fetches instructions from instruction memory.
- Closes the loop after the branch mux: it consumes the branch and zero-flag resolution, computes PC+4 and the branch target, and registers the selected next PC.
- Presents each fetched word to decode using a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, address loaded into the PC on reset.
- ADDR_W, 32, PC/address width (instruction and data fixed at 32 bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address (current PC).
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode accepts instr this cycle.
- instr  out  32  held instruction word.
- instr_pc  out  ADDR_W  address of the held instruction.
- pc_plus4  out  ADDR_W  instr_pc + 4 (combinational from instr_pc).
- branch  in  1  held instruction is a conditional branch.
- alu_zero  in  1  ALU zero flag for the held instruction.
- branch_offset  in  32  sign-extended 16-bit immediate (word offset).
- instr_count  out  32  number of instructions accepted by decode.

Behaviour:
- Reset is asynchronous and active-high; outputs are valid while rst=1. Reset values:
  - state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=RESET_PC, instr_count=0.
- FSM state BOOT: imem_req=0; always moves to FETCH on the next edge (one idle cycle after reset release).
- FSM state FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - An ack may arrive in the first FETCH cycle (zero-wait memory).
- FSM state HOLD:
  - imem_req=0; instr and instr_pc stay stable; instr_valid=1.
  - On instr_valid & instr_ready (handshake): pc<=next_pc, instr_valid<=0, instr_count<=instr_count+1, go to FETCH.
  - Without a handshake, stay in HOLD indefinitely.
- imem_ack is ignored whenever imem_req=0 (BOOT, HOLD).
- next_pc (evaluated only in the handshake cycle):
  - taken = branch & alu_zero.
  - target = instr_pc + 4 + (branch_offset << 2).
  - next_pc = taken ? target : instr_pc + 4.
  - All arithmetic is modulo 2^ADDR_W; wrap past 32'hFFFF_FFFC is silent.
- branch, alu_zero and branch_offset are don't-care outside the handshake cycle.
- Throughput: one instruction per 2 cycles minimum (FETCH with same-cycle ack, then HOLD with instr_ready=1).
- instr_count wraps 32'hFFFF_FFFF -> 0.
- Reset mid-fetch or mid-hold: immediate return to reset values; the pending fetch is abandoned and a late imem_ack is ignored, because BOOT drives imem_req=0.
- Low address bits: the PC is not forced aligned; a RESET_PC whose low two bits are nonzero is a configuration error.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state enum {BOOT, FETCH, HOLD}.
  - INSTR_BYTES=4 and default RESET_PC constant.
  - Word-offset shift amount (2).
- Sub-module next_pc_calc (combinational: instr_pc, branch, alu_zero, branch_offset -> pc_plus4, next_pc).
  - Reusable by a later jump extension.
- FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release, memory acks in first FETCH cycle, instr_ready=1 constantly, branch=0.
  - Required: fetch addresses 0x0, 0x4, 0x8 with instr_valid pulses two cycles apart.
  - Required: instr_count=3 after the third handshake.
- Taken branch: held instr_pc=0x10, branch=1, alu_zero=1, branch_offset=32'hFFFF_FFFC (-4).
  - Required: next imem_addr = 0x14 - 0x10 = 0x04.
  - Repeat with offset 3: required next imem_addr=0x20.
- Untaken branch: branch=1, alu_zero=0, instr_pc=0x10.
  - Required: next imem_addr=0x14.
  - Also branch=0, alu_zero=1: required next imem_addr=0x14.
- Memory wait states: imem_ack delayed 3 cycles.
  - Required: imem_req stays 1 and imem_addr stays stable for all 3 cycles; rdata 0xDEADBEEF appears on instr.
  - Required: a stray ack injected during HOLD has no effect.
- Decode backpressure: instr_ready=0 for 5 cycles in HOLD.
  - Required: instr, instr_pc and instr_valid stable; no imem_req; instr_count unchanged until ready rises.
- Async reset during FETCH with ack arriving in the following cycle.
  - Required: outputs at reset values immediately; the ack is ignored.
  - Required: fetch restarts at RESET_PC after the BOOT cycle.
  - Wrap check: instr_pc=0xFFFF_FFFC, untaken, required next_pc=0x0.
